// File: rtl/coherent_bus_ctrl.sv
// N-core snooping coherence bus controller: arbitrates icache fetches, dcache
// writebacks and coherence transactions from CPUS cores onto one RAM port.

module coherent_bus_lane #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          is_own,
  input  logic          is_rsp,
  input  logic          st_wb,
  input  logic          st_if,
  input  logic          st_sn,
  input  logic          st_ld,
  input  logic          st_c2c,
  input  logic          acc,
  input  logic          inv,
  input  logic [AW-1:0] own_addr,
  input  logic [DW-1:0] ramload,
  input  logic [DW-1:0] rsp_data,
  output logic          iwait,
  output logic          dwait,
  output logic          ccwait,
  output logic          ccinv,
  output logic [AW-1:0] ccsnoopaddr,
  output logic [DW-1:0] iload,
  output logic [DW-1:0] dload
);
  logic d_xfer;

  // A responder in C2C moves a data beat just like the requester does.
  assign d_xfer = (is_own && (st_wb || st_ld || st_c2c)) || (is_rsp && st_c2c);

  always_comb begin
    iwait       = !(is_own && st_if && acc);
    dwait       = !(d_xfer && acc);
    ccwait      = !is_own && (st_wb || st_ld || st_sn || (st_c2c && !is_rsp));
    ccinv       = !is_own && st_sn && inv;
    ccsnoopaddr = ((!is_own && st_sn) || (is_rsp && st_c2c)) ? own_addr : '0;
    iload       = (is_own && st_if) ? ramload : '0;
    dload       = '0;
    if (is_own && st_ld)  dload = ramload;
    if (is_own && st_c2c) dload = rsp_data;
  end
endmodule

module coherent_bus_ctrl #(
  parameter int CPUS  = 2,
  parameter int WORDS = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0][AW-1:0]  iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0][DW-1:0]  iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0][AW-1:0]  daddr,
  input  logic [CPUS-1:0][DW-1:0]  dstore,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS-1:0][DW-1:0]  dload,
  input  logic [CPUS-1:0]          cctrans,
  input  logic [CPUS-1:0]          ccwrite,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS-1:0][AW-1:0]  ccsnoopaddr,
  input  logic [1:0]               ramstate,
  input  logic [DW-1:0]            ramload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [AW-1:0]            ramaddr,
  output logic [DW-1:0]            ramstore
);
  localparam int OW = $clog2(CPUS);
  localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BW-1:0] LAST = BW'(WORDS - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, WB, SNOOP, IFETCH, LDRAM, C2C} state_t;

  state_t        state;
  logic [OW-1:0] owner, resp, rr;
  logic          resp_vld;
  logic [BW-1:0] beat;

  logic          acc;
  logic [CPUS-1:0] own_oh, peer_dirty;
  logic          snoop_done;
  logic [OW-1:0] dirty_idx, rr_next;
  logic [OW:0]   wb_pick, cc_pick, if_pick;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [OW:0] rr_pick(input logic [CPUS-1:0] req,
                                          input logic [OW-1:0] ptr);
    logic [OW:0] r;
    int idx;
    r = '0;
    for (int i = CPUS-1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= CPUS) idx = idx - CPUS;
      if (req[idx]) r = {1'b1, OW'(idx)};
    end
    return r;
  endfunction

  assign acc        = (ramstate == RAM_ACCESS);
  assign own_oh     = CPUS'(1) << owner;
  assign snoop_done = &(cctrans | own_oh);
  assign peer_dirty = ccwrite & ~own_oh;
  assign rr_next    = (owner == OW'(CPUS-1)) ? '0 : owner + 1'b1;
  assign wb_pick    = rr_pick(dWEN, rr);
  assign cc_pick    = rr_pick(cctrans, rr);
  assign if_pick    = rr_pick(iREN, rr);

  always_comb begin
    dirty_idx = '0;
    for (int j = CPUS-1; j >= 0; j--)
      if (peer_dirty[j]) dirty_idx = OW'(j);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      owner    <= '0;
      resp     <= '0;
      resp_vld <= 1'b0;
      beat     <= '0;
      rr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_pick[OW]) begin
            state <= WB;     owner <= wb_pick[OW-1:0];
          end else if (cc_pick[OW]) begin
            state <= SNOOP;  owner <= cc_pick[OW-1:0];
          end else if (if_pick[OW]) begin
            state <= IFETCH; owner <= if_pick[OW-1:0];
          end
        end
        WB, LDRAM, C2C: begin
          // BUSY/ERROR leave the beat untouched so it is retried.
          if (acc) begin
            if (beat == LAST) begin
              state    <= IDLE;
              beat     <= '0;
              rr       <= rr_next;
              resp_vld <= 1'b0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        IFETCH: begin
          if (acc) begin
            state <= IDLE;
            rr    <= rr_next;
          end
        end
        SNOOP: begin
          if (snoop_done) begin
            if (!dREN[owner]) begin
              state <= IDLE;
              rr    <= rr_next;
            end else if (|peer_dirty) begin
              state    <= C2C;
              resp     <= dirty_idx;
              resp_vld <= 1'b1;
            end else begin
              state <= LDRAM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      WB: begin
        ramWEN = 1'b1; ramaddr = daddr[owner]; ramstore = dstore[owner];
      end
      IFETCH: begin
        ramREN = 1'b1; ramaddr = iaddr[owner];
      end
      LDRAM: begin
        ramREN = 1'b1; ramaddr = daddr[owner];
      end
      C2C: begin
        // Dirty data goes to the requester and back to RAM in the same beat.
        ramWEN = 1'b1; ramaddr = daddr[resp]; ramstore = dstore[resp];
      end
      default: ;
    endcase
  end

  for (genvar c = 0; c < CPUS; c++) begin : g_lane
    coherent_bus_lane #(.AW(AW), .DW(DW)) u_lane (
      .is_own      (owner == OW'(c)),
      .is_rsp      (resp_vld && (resp == OW'(c))),
      .st_wb       (state == WB),
      .st_if       (state == IFETCH),
      .st_sn       (state == SNOOP),
      .st_ld       (state == LDRAM),
      .st_c2c      (state == C2C),
      .acc         (acc),
      .inv         (ccwrite[owner]),
      .own_addr    (daddr[owner]),
      .ramload     (ramload),
      .rsp_data    (dstore[resp]),
      .iwait       (iwait[c]),
      .dwait       (dwait[c]),
      .ccwait      (ccwait[c]),
      .ccinv       (ccinv[c]),
      .ccsnoopaddr (ccsnoopaddr[c]),
      .iload       (iload[c]),
      .dload       (dload[c])
    );
  end
endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// Bench for coherent_bus_ctrl (4 cores, 4-word blocks): vector table, directed
// multi-cycle sequences, then random fetch/writeback traffic against a model.
`timescale 1ns/1ps
module tb_coherent_bus_ctrl;
  localparam int CPUS = 4, WORDS = 4, AW = 32, DW = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam int KWB = 0, KIF = 1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [CPUS-1:0] iREN, dREN, dWEN, cctrans, ccwrite;
  logic [CPUS-1:0][AW-1:0] iaddr, daddr, ccsnoopaddr;
  logic [CPUS-1:0][DW-1:0] dstore, iload, dload;
  logic [CPUS-1:0] iwait, dwait, ccwait, ccinv;
  logic [1:0] ramstate;
  logic [DW-1:0] ramload, ramstore;
  logic ramREN, ramWEN;
  logic [AW-1:0] ramaddr;

  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  coherent_bus_ctrl #(.CPUS(CPUS), .WORDS(WORDS), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore)
  );

  typedef struct packed {
    logic [3:0]  iren, dwen, cct, ccw;
    logic        exp_ren, exp_wen;
    logic [31:0] exp_addr;
    logic [3:0]  exp_ccw, exp_inv;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    ramstate = FREE;
    nRST = 1'b0;
    step(); step();
    nRST = 1'b1;
  endtask

  // random-phase model state
  logic [3:0] wreq, ireq;
  bit busy;
  int kind, own, left, rr_m;

  initial begin
    logic [3:0] m;
    int k;
    tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h1000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h1008, 4'b0000, 4'b0000};
    tbl[2] = '{4'b0001, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h200C, 4'b0111, 4'b0000};
    tbl[3] = '{4'b0000, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h2004, 4'b1101, 4'b0000};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000, 4'b0000, 4'b0000};
    tbl[5] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h100C, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0001, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0000, 4'b1011, 4'b1011};
    tbl[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 1'b0, 1'b1, 32'h2000, 4'b1110, 4'b0000};

    for (int c = 0; c < CPUS; c++) begin
      iaddr[c]  = 32'h1000 + 32'(4*c);
      daddr[c]  = 32'h2000 + 32'(4*c);
      dstore[c] = 32'hD000_0000 + 32'(c);
    end
    ramload = 32'h0;
    ramstate = ACCESS;
    iREN = '1; dWEN = '1; dREN = '0; cctrans = '1; ccwrite = '0;

    // held in reset with every request up: nothing may be granted
    #2;
    chk("reset_out", {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, ccwait, ccinv},
        {1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0});
    step();
    chk("reset_hold", {ramREN, ramWEN, iwait, dwait, iload, dload},
        {1'b0, 1'b0, 4'hF, 4'hF, 128'h0, 128'h0});

    // arbitration / first-state vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      iREN = tbl[i].iren; dWEN = tbl[i].dwen; cctrans = tbl[i].cct; ccwrite = tbl[i].ccw;
      @(negedge CLK);
      chk($sformatf("vec%0d_idle", i), {ramREN, ramWEN, ccwait}, 6'b0);
      step();
      @(negedge CLK);
      chk($sformatf("vec%0d", i), {ramREN, ramWEN, ramaddr, ccwait, ccinv},
          {tbl[i].exp_ren, tbl[i].exp_wen, tbl[i].exp_addr, tbl[i].exp_ccw, tbl[i].exp_inv});
    end

    // reset in the middle of a writeback
    do_reset();
    dWEN = 4'b0010; ramstate = ACCESS;
    step(); step(); ramstate = BUSY;
    @(negedge CLK);
    chk("rst_wb_active", {ramWEN, ramaddr}, {1'b1, daddr[1]});
    nRST = 1'b0; #1;
    chk("rst_wb_async", {ramWEN, ramREN, iwait, dwait, ccwait}, {1'b0, 1'b0, 4'hF, 4'hF, 4'h0});
    step();
    nRST = 1'b1; dWEN = '0; iREN = 4'b0011; ramstate = ACCESS;
    @(negedge CLK);
    chk("rst_wb_idle", {ramWEN, ramREN}, 2'b00);
    step();
    @(negedge CLK);
    chk("rst_rr0", {ramREN, ramaddr}, {1'b1, 32'h1000});

    // round-robin fairness with RAM ACCESS every other cycle
    do_reset();
    iREN = 4'b1111;
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      step();
      ramstate = (c % 2 == 1) ? ACCESS : BUSY;
      ramload = $urandom;
      @(negedge CLK);
      if (ramREN && ramstate == ACCESS) begin
        m = ~(4'b0001 << (k % 4));
        chk($sformatf("fair_addr%0d", k), ramaddr, 32'h1000 + 32'(4*(k % 4)));
        chk($sformatf("fair_iload%0d", k), iload[k % 4], ramload);
        chk($sformatf("fair_iwait%0d", k), iwait, m);
        k++;
      end
    end
    chk("fair_count", k, 5);

    // writeback outranks fetch; peers frozen during WB
    do_reset();
    dWEN = 4'b0100; iREN = 4'b0001; ramstate = ACCESS;
    @(negedge CLK);
    step();
    for (int b = 0; b < WORDS; b++) begin
      @(negedge CLK);
      chk($sformatf("prio_wb%0d", b), {ramWEN, ramREN, ramaddr, ramstore, ccwait, dwait},
          {1'b1, 1'b0, daddr[2], dstore[2], 4'b1011, 4'b1011});
      step();
    end
    dWEN = '0;
    @(negedge CLK);
    chk("prio_idle", {ramWEN, ramREN}, 2'b00);
    step(); ramload = 32'hCAFE_0001;
    @(negedge CLK);
    chk("prio_fetch", {ramREN, ramWEN, ramaddr, iload[0], iwait},
        {1'b1, 1'b0, iaddr[0], 32'hCAFE_0001, 4'b1110});

    // snoop miss -> LDRAM
    do_reset();
    ramstate = ACCESS; cctrans = 4'b0010; dREN = 4'b0010;
    @(negedge CLK);
    step();
    @(negedge CLK);
    chk("miss_snoop", {ccwait, ccinv, ccsnoopaddr[0], ccsnoopaddr[1], ramREN, ramWEN},
        {4'b1101, 4'b0000, daddr[1], 32'h0, 1'b0, 1'b0});
    step(); cctrans = 4'b1111;
    @(negedge CLK);
    step();
    for (int b = 0; b < WORDS; b++) begin
      ramload = $urandom;
      @(negedge CLK);
      chk($sformatf("miss_ld%0d", b), {ramREN, ramWEN, ramaddr, ccwait, ccinv, dwait},
          {1'b1, 1'b0, daddr[1], 4'b1101, 4'b0000, 4'b1101});
      chk($sformatf("miss_dload%0d", b), dload[1], ramload);
      step();
    end
    cctrans = '0; dREN = '0;
    @(negedge CLK);
    chk("miss_done", {ramREN, ramWEN}, 2'b00);

    // BusRdX with a dirty peer -> cache-to-cache
    do_reset();
    ramstate = ACCESS; cctrans = 4'b0001; ccwrite = 4'b0001; dREN = 4'b0001;
    @(negedge CLK);
    step();
    @(negedge CLK);
    chk("c2c_inv", {ccinv, ccsnoopaddr[3]}, {4'b1110, daddr[0]});
    step(); cctrans = 4'b1111; ccwrite = 4'b1001;
    @(negedge CLK);
    chk("c2c_wait", {ccwait, ramWEN}, {4'b1110, 1'b0});
    step();
    for (int b = 0; b < WORDS; b++) begin
      @(negedge CLK);
      chk($sformatf("c2c_beat%0d", b), {ramWEN, ramREN, ramaddr, ramstore, ccwait, dwait, ccsnoopaddr[3]},
          {1'b1, 1'b0, daddr[3], dstore[3], 4'b0110, 4'b0110, daddr[0]});
      chk($sformatf("c2c_dload%0d", b), dload[0], dstore[3]);
      step();
    end
    cctrans = '0; ccwrite = '0; dREN = '0;
    @(negedge CLK);
    chk("c2c_done", {ramWEN, ramREN, ccwait}, 6'b0);

    // invalidate-only upgrade ends at snoop, then rr points past the owner
    do_reset();
    cctrans = 4'b0100; ccwrite = 4'b0100;
    @(negedge CLK);
    step(); cctrans = 4'b1111;
    @(negedge CLK);
    chk("upg_inv", ccinv, 4'b1011);
    step(); cctrans = '0; ccwrite = '0; iREN = 4'b1011;
    @(negedge CLK);
    chk("upg_idle", {ramREN, ramWEN, ccwait, ccinv}, 10'b0);
    step();
    @(negedge CLK);
    chk("upg_rr", {ramREN, ramaddr}, {1'b1, 32'h100C});

    // ERROR during LDRAM beat 0 is retried
    do_reset();
    cctrans = 4'b0100; dREN = 4'b0100; ramstate = ERROR;
    @(negedge CLK);
    step(); cctrans = 4'b1111;
    @(negedge CLK);
    step();
    for (int e = 0; e < 3; e++) begin
      @(negedge CLK);
      chk($sformatf("err_hold%0d", e), {ramREN, ramaddr, dwait}, {1'b1, daddr[2], 4'b1111});
      step();
    end
    ramstate = ACCESS;
    for (int b = 0; b < WORDS; b++) begin
      @(negedge CLK);
      chk($sformatf("err_beat%0d", b), {ramREN, ramaddr, dwait}, {1'b1, daddr[2], 4'b1011});
      step();
    end
    cctrans = '0; dREN = '0;
    @(negedge CLK);
    chk("err_done", ramREN, 1'b0);

    // random fetch/writeback traffic against a request-level model
    do_reset();
    wreq = '0; ireq = '0; busy = 0; rr_m = 0; kind = KWB; own = 0; left = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] e_iw, e_dw, e_ccw;
      logic [CPUS-1:0][DW-1:0] e_il, e_dl;
      logic e_ren, e_wen, acc;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_store;
      for (int q = 0; q < CPUS; q++) begin
        if (!wreq[q] && $urandom_range(0, 7) == 0) wreq[q] = 1'b1;
        if (!ireq[q] && $urandom_range(0, 5) == 0) ireq[q] = 1'b1;
        iaddr[q] = $urandom; daddr[q] = $urandom; dstore[q] = $urandom;
      end
      iREN = ireq; dWEN = wreq;
      ramstate = 2'($urandom_range(0, 3));
      ramload = $urandom;
      @(negedge CLK);
      acc = (ramstate == ACCESS);
      e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
      e_iw = 4'hF; e_dw = 4'hF; e_ccw = 4'h0; e_il = '0; e_dl = '0;
      if (busy) begin
        if (kind == KWB) begin
          e_wen = 1; e_addr = daddr[own]; e_store = dstore[own]; e_dw[own] = !acc;
          for (int q = 0; q < CPUS; q++) e_ccw[q] = (q != own);
        end else begin
          e_ren = 1; e_addr = iaddr[own]; e_il[own] = ramload; e_iw[own] = !acc;
        end
      end
      chk("rand_ram", {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, ccwait, ccinv},
          {e_ren, e_wen, e_addr, e_store, e_iw, e_dw, e_ccw, 4'h0});
      chk("rand_iload", iload, e_il);
      chk("rand_dload", dload, e_dl);
      @(posedge CLK);
      if (busy) begin
        if (acc) begin
          left--;
          if (left == 0) begin
            busy = 0;
            if (kind == KWB) wreq[own] = 1'b0; else ireq[own] = 1'b0;
            rr_m = (own + 1) % CPUS;
          end
        end
      end else begin
        // writebacks outrank fetches; first requester at or after rr_m wins
        for (int i = 0; i < CPUS && !busy; i++)
          if (wreq[(rr_m + i) % CPUS]) begin
            busy = 1; kind = KWB; own = (rr_m + i) % CPUS; left = WORDS;
          end
        for (int i = 0; i < CPUS && !busy; i++)
          if (ireq[(rr_m + i) % CPUS]) begin
            busy = 1; kind = KIF; own = (rr_m + i) % CPUS; left = 1;
          end
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
